// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), restoring, one quotient bit per clock.
// Optional DIV_UNIT_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish one cycle after accept.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   out_q, out_d;

    logic           is_signed_c;
    logic [W-1:0]   a_abs_c;
    logic [W-1:0]   b_abs_c;
    logic [W:0]     trial_c;
    logic [W:0]     diff_c;
    logic [W-1:0]   rem_step_c;
    logic [W-1:0]   quo_step_c;
    logic [W-1:0]   q_fix_c;
    logic [W-1:0]   r_fix_c;
    logic [W-1:0]   res_c;

    // Operand conditioning at accept time
    always_comb begin
        is_signed_c = ~op[0];
        a_abs_c     = (is_signed_c && A[W-1]) ? W'(~A + W'(1)) : A;
        b_abs_c     = (is_signed_c && B[W-1]) ? W'(~B + W'(1)) : B;
    end

    // One restoring step plus sign fix-up of the step result
    always_comb begin
        trial_c    = {rem_q, quo_q[W-1]};
        diff_c     = trial_c - {1'b0, dvs_q};
        rem_step_c = diff_c[W] ? trial_c[W-1:0] : diff_c[W-1:0];
        quo_step_c = {quo_q[W-2:0], ~diff_c[W]};
        q_fix_c    = q_neg_q ? W'(~quo_step_c + W'(1)) : quo_step_c;
        r_fix_c    = r_neg_q ? W'(~rem_step_c + W'(1)) : rem_step_c;
        // Zero divisor: the unsigned datapath yields all ones; keep it unnegated
        if (dz_q) begin
            q_fix_c = '1;
        end
        res_c = op_q[1] ? r_fix_c : q_fix_c;
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    op_d    = op;
                    quo_d   = a_abs_c;
                    dvs_d   = b_abs_c;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = is_signed_c & (A[W-1] ^ B[W-1]);
                    r_neg_d = is_signed_c & A[W-1];
                    dz_d    = (B == '0);
`ifdef DIV_UNIT_FAST_SPECIAL_EN
                    if (B == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        out_d   = op[1] ? A : '1;
                    end else if (is_signed_c && (A == 32'h8000_0000) && (B == '1)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        out_d   = op[1] ? '0 : 32'h8000_0000;
                    end
`endif
                end
            end
            CALC: begin
                quo_d = quo_step_c;
                rem_d = rem_step_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    out_d   = res_c;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus ignored-start and mid-operation reset sequences.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_tests;
    int n_fail;

`ifdef DIV_UNIT_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[16];

    div_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .op   (op),
        .busy (busy),
        .done (done),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Launch one operation, return result and latency (accept edge counts as 1)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        op = 2'($urandom);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out;
        @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          pulses;
        logic [31:0] first_out;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{2'd0, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0};
        vecs[3]  = '{2'd2, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   1'b0};
        vecs[4]  = '{2'd0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[5]  = '{2'd1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[6]  = '{2'd2, 32'h12345678,   32'd0,          32'h12345678,   1'b1};
        vecs[7]  = '{2'd3, 32'h12345678,   32'd0,          32'h12345678,   1'b1};
        vecs[8]  = '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[9]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[10] = '{2'd1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[11] = '{2'd3, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0};
        vecs[12] = '{2'd0, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0};
        vecs[13] = '{2'd2, 32'd100,        32'hFFFFFFF9,   32'd2,          1'b0};
        vecs[14] = '{2'd1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[15] = '{2'd0, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   1'b1};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_out", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  vecs[i].special ? 32'(SPEC_LAT) : 32'(NORM_LAT));
        end

        // Start pulses while busy must be ignored
        @(negedge clk);
        op = 2'd1; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        pulses = 0;
        first_out = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5 || c == 10) begin
                start = 1'b1; op = 2'd0; A = $urandom; B = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) first_out = out;
            end
        end
        check("ignored_start_pulses", 32'(pulses), 32'd1);
        check("ignored_start_out", first_out, 32'd14);
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of an iteration sequence
        @(negedge clk);
        op = 2'd0; A = 32'h7FFFFFFF; B = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd1, 32'd9, 32'd3, res, lat);
        check("post_reset_out", res, 32'd3);
        check("post_reset_latency", 32'(lat), 32'(NORM_LAT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
